dmem_responder: RTL and testbench

- Data-memory responder: the memory-side counterpart of the instruction control unit's MemRead/MemWrite request outputs.
- Accepts one load or store request at a time and captures the opcode, address and write data.
- Performs the access on an internal word-organised RAM after a programmable number of wait cycles, then returns a one-cycle ready pulse with load data.
- Sits between the MIPS32 load/store datapath and data storage; big-endian byte lanes.

---
 rtl/mips_pkg.sv | 13 +
 rtl/dmem_lane_align.sv | 32 +++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, access sizes and responder FSM states shared by the data-memory path
package mips_pkg;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: big-endian byte-lane steering, load extension and legality check
// ports: st/opcode/offset/wdata/ram_word in; be (bit3 = bits 31:24), wword, rdata, bad out
module dmem_lane_align
  import mips_pkg::*;
(
  input  logic        st,
  input  logic [5:0]  opcode,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] ram_word,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        bad
);
  size_e       size;
  logic        legal;
  logic        sgn;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    legal = st ? (opcode inside {OP_SB, OP_SH, OP_SW}) : (opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
    size  = (opcode inside {OP_LW, OP_SW}) ? SZ_WORD : (opcode inside {OP_LH, OP_LHU, OP_SH}) ? SZ_HALF : SZ_BYTE;
    sgn   = opcode inside {OP_LB, OP_LH};
    bad   = !legal || (size == SZ_HALF && offset[0]) || (size == SZ_WORD && offset != 2'b00);
    be    = bad ? 4'b0000 : size == SZ_WORD ? 4'b1111 : size == SZ_HALF ? (offset[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> offset;
    wword = size == SZ_WORD ? wdata : size == SZ_HALF ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    b     = ram_word[{~offset, 3'b000} +: 8];
    h     = offset[1] ? ram_word[15:0] : ram_word[31:16];
    rdata = bad ? '0 : size == SZ_WORD ? ram_word : size == SZ_HALF ? {{16{sgn & h[15]}}, h} : {{24{sgn & b[7]}}, b};
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder over a word RAM with programmable wait
// ports: mem_read/mem_write/opcode/addr/wdata request in; rdata, ready (pulse), busy, err (pulse) out
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [5:0]          op_q, op_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                store_q, store_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [31:0]         mem [DEPTH];
  logic [3:0]          be;
  logic [31:0]         wword;
  logic [31:0]         ld_data;
  logic                bad;
  logic                unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];
  dmem_lane_align u_align (
    .st      (store_q),
    .opcode  (op_q),
    .offset  (addr_q[1:0]),
    .wdata   (wdata_q),
    .ram_word(mem[addr_q[ADDR_W+1:2]]),
    .be      (be),
    .wword   (wword),
    .rdata   (ld_data),
    .bad     (bad)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    store_d = store_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_read && mem_write) err_d = 1'b1;
        else if (mem_read || mem_write) begin
          op_d    = opcode;
          addr_d  = addr[ADDR_W+1:0];
          wdata_d = wdata;
          store_d = mem_write;
          cnt_d   = CW'(WAIT_CYCLES - 1);
          state_d = WAIT_CYCLES > 0 ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? ST_ACCESS : ST_WAIT;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        ready_d = 1'b1;
        err_d   = bad;
        rdata_d = store_q ? rdata_q : ld_data;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end
  // RAM is not reset; reset clears state_q asynchronously, so a dropped store never reaches here
  always_ff @(posedge clk) begin
    if (state_q == ST_ACCESS && store_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[ADDR_W+1:2]][8*i +: 8] <= wword[8*i +: 8];
  end
  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = state_q != ST_IDLE;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a byte-array model
module tb_dmem_responder;
  import mips_pkg::*;
  localparam int WC = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready, busy, err;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  ref_mem [1024];
  logic [31:0] exp_rd = '0;
  dmem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .opcode(opcode),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  function automatic int ref_size(logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction
  function automatic bit ref_bad(bit st, logic [5:0] op, logic [31:0] a);
    int sz = ref_size(op);
    bit st_op = op inside {OP_SB, OP_SH, OP_SW};
    if (sz == 0 || st != st_op) return 1'b1;
    return (a % sz) != 0;
  endfunction
  function automatic logic [31:0] ref_load(logic [5:0] op, logic [31:0] a);
    int sz = ref_size(op);
    int base = int'(a % 1024);
    longint v = 0;
    for (int i = 0; i < sz; i++) v = (v << 8) | longint'(ref_mem[base + i]);
    if ((op == OP_LB || op == OP_LH) && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction
  function automatic void ref_store(logic [5:0] op, logic [31:0] a, logic [31:0] wd);
    int sz = ref_size(op);
    int base = int'(a % 1024);
    for (int i = 0; i < sz; i++) ref_mem[base + i] = 8'(wd >> (8 * (sz - 1 - i)));
  endfunction
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 30) begin @(negedge clk); n++; end
  endtask
  task automatic req(input bit wr, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd_o, output logic er_o, output int lat);
    wait_idle();
    mem_read = !wr; mem_write = wr; opcode = op; addr = a; wdata = wd;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    lat = 1;
    while (!ready && lat < 20) begin @(posedge clk); #1; lat++; end
    rd_o = rdata; er_o = err;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_tests++;
    if ({rdata, ready, busy, err} !== 35'd0) begin n_fail++; $display("FAIL reset outputs got=%h exp=0", {rdata, ready, busy, err}); end
    @(negedge clk); rst = 1'b0;
  endtask
  task automatic test_fill();
    logic [31:0] r, d; logic e; int lat;
    for (int w = 0; w < 64; w++) begin
      d = $urandom;
      req(1'b1, OP_SW, 32'(w * 4), d, r, e, lat);
      ref_store(OP_SW, 32'(w * 4), d);
      n_tests++;
      if (e !== 1'b0 || lat != WC + 2 || r !== exp_rd) begin
        n_fail++; $display("FAIL fill w=%0d err=%b lat=%0d rdata=%h exp err=0 lat=%0d rdata=%h", w, e, lat, r, WC + 2, exp_rd);
      end
    end
  endtask
  typedef struct { bit wr; logic [5:0] op; logic [31:0] a; logic [31:0] wd; logic [31:0] exp; bit e; } vec_t;
  task automatic test_directed();
    vec_t v [15] = '{
      '{1'b1, OP_SW,  32'h10,  32'h89ABCDEF, 32'h0,        1'b0},
      '{1'b0, OP_LW,  32'h10,  32'h0,        32'h89ABCDEF, 1'b0},
      '{1'b0, OP_LB,  32'h10,  32'h0,        32'hFFFFFF89, 1'b0},
      '{1'b0, OP_LBU, 32'h10,  32'h0,        32'h00000089, 1'b0},
      '{1'b0, OP_LH,  32'h12,  32'h0,        32'hFFFFCDEF, 1'b0},
      '{1'b0, OP_LHU, 32'h12,  32'h0,        32'h0000CDEF, 1'b0},
      '{1'b0, OP_LB,  32'h13,  32'h0,        32'hFFFFFFEF, 1'b0},
      '{1'b1, OP_SB,  32'h11,  32'h00000055, 32'h0,        1'b0},
      '{1'b0, OP_LW,  32'h10,  32'h0,        32'h8955CDEF, 1'b0},
      '{1'b1, OP_SH,  32'h12,  32'h00001234, 32'h0,        1'b0},
      '{1'b0, OP_LW,  32'h10,  32'h0,        32'h89551234, 1'b0},
      '{1'b0, OP_LW,  32'h12,  32'h0,        32'h00000000, 1'b1},
      '{1'b1, OP_SH,  32'h11,  32'h0000BEEF, 32'h0,        1'b1},
      '{1'b0, OP_LW,  32'h10,  32'h0,        32'h89551234, 1'b0},
      '{1'b0, OP_LW,  32'h410, 32'h0,        32'h89551234, 1'b0}
    };
    logic [31:0] r; logic e; int lat;
    for (int i = 0; i < 15; i++) begin
      req(v[i].wr, v[i].op, v[i].a, v[i].wd, r, e, lat);
      if (!v[i].wr) exp_rd = v[i].exp;
      else if (!v[i].e) ref_store(v[i].op, v[i].a, v[i].wd);
      n_tests++;
      if (r !== exp_rd || e !== v[i].e || lat != WC + 2) begin
        n_fail++; $display("FAIL directed[%0d] rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d", i, r, e, lat, exp_rd, v[i].e, WC + 2);
      end
      @(posedge clk); #1;
      n_tests++;
      if (ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL directed_pulse[%0d] ready=%b err=%b busy=%b exp 0 0 0", i, ready, err, busy);
      end
    end
  endtask
  task automatic test_both_strobes();
    wait_idle();
    mem_read = 1'b1; mem_write = 1'b1; opcode = OP_LW; addr = 32'h10;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    n_tests++;
    if ({err, ready, busy} !== 3'b100) begin n_fail++; $display("FAIL both_strobes err/ready/busy got=%b exp=100", {err, ready, busy}); end
    @(posedge clk); #1;
    n_tests++;
    if ({err, ready, busy} !== 3'b000) begin n_fail++; $display("FAIL both_strobes_after got=%b exp=000", {err, ready, busy}); end
  endtask
  task automatic test_busy_ignore();
    logic [31:0] a_val, b_val, r; logic e; int n;
    a_val = $urandom;
    b_val = ~ref_load(OP_LW, 32'h44);
    wait_idle();
    mem_write = 1'b1; opcode = OP_SW; addr = 32'h40; wdata = a_val;
    @(posedge clk); #1;
    addr = 32'h44; wdata = b_val;
    n = 1;
    while (!ready && n < 20) begin @(posedge clk); #1; n++; end
    mem_write = 1'b0;
    ref_store(OP_SW, 32'h40, a_val);
    n_tests++;
    if (n != WC + 2) begin n_fail++; $display("FAIL busy_ignore lat got=%0d exp=%0d", n, WC + 2); end
    req(1'b0, OP_LW, 32'h44, 32'h0, r, e, n);
    exp_rd = ref_load(OP_LW, 32'h44);
    n_tests++;
    if (r !== exp_rd || e !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_0x44 got=%h exp=%h", r, exp_rd); end
    req(1'b0, OP_LW, 32'h40, 32'h0, r, e, n);
    exp_rd = a_val;
    n_tests++;
    if (r !== a_val || e !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_0x40 got=%h exp=%h", r, a_val); end
  endtask
  task automatic test_back_to_back();
    int s1, s2;
    logic [31:0] r1, r2;
    s1 = 0; s2 = 0; r1 = '0; r2 = '0;
    wait_idle();
    mem_read = 1'b1; opcode = OP_LH; addr = 32'h12;
    @(posedge clk); #1;
    for (int s = 1; s <= 2 * WC + 6; s++) begin
      if (ready && s1 == 0) begin s1 = s; r1 = rdata; end
      else if (ready && s2 == 0) begin s2 = s; r2 = rdata; end
      @(posedge clk); #1;
    end
    mem_read = 1'b0;
    exp_rd = ref_load(OP_LH, 32'h12);
    n_tests++;
    if (s1 != WC + 2 || s2 - s1 != WC + 3) begin n_fail++; $display("FAIL b2b timing s1=%0d s2=%0d exp s1=%0d gap=%0d", s1, s2, WC + 2, WC + 3); end
    n_tests++;
    if (r1 !== exp_rd || r2 !== exp_rd) begin n_fail++; $display("FAIL b2b data got=%h,%h exp=%h", r1, r2, exp_rd); end
    wait_idle();
    wait_idle();
  endtask
  task automatic test_random();
    logic [5:0] lds [5] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    logic [5:0] sts [3] = '{OP_SB, OP_SH, OP_SW};
    logic [31:0] a, d, r, er; logic e; logic [5:0] op; bit wr, eb; int lat;
    for (int k = 0; k < 200; k++) begin
      wr = $urandom_range(0, 1);
      op = wr ? sts[$urandom_range(0, 2)] : lds[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 255));
      d = $urandom;
      eb = ref_bad(wr, op, a);
      er = wr ? exp_rd : (eb ? 32'h0 : ref_load(op, a));
      req(wr, op, a, d, r, e, lat);
      if (wr && !eb) ref_store(op, a, d);
      exp_rd = er;
      n_tests++;
      if (r !== er || e !== eb || lat != WC + 2) begin
        n_fail++; $display("FAIL random[%0d] op=%b a=%h rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d", k, op, a, r, e, lat, er, eb, WC + 2);
      end
    end
  endtask
  task automatic test_reset_mid();
    logic [31:0] r; logic e; int lat;
    req(1'b0, OP_LW, 32'h10, 32'h0, r, e, lat);
    exp_rd = ref_load(OP_LW, 32'h10);
    wait_idle();
    mem_write = 1'b1; opcode = OP_SW; addr = 32'h20; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_write = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || rdata !== exp_rd) begin n_fail++; $display("FAIL reset_mid_pre busy=%b rdata=%h exp 1 %h", busy, rdata, exp_rd); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({rdata, ready, busy, err} !== 35'd0) begin n_fail++; $display("FAIL reset_mid outputs got=%h exp=0", {rdata, ready, busy, err}); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    exp_rd = '0;
    req(1'b0, OP_LW, 32'h20, 32'h0, r, e, lat);
    exp_rd = ref_load(OP_LW, 32'h20);
    n_tests++;
    if (r !== exp_rd || e !== 1'b0 || lat != WC + 2) begin n_fail++; $display("FAIL reset_mid_load got=%h err=%b lat=%0d exp=%h", r, e, lat, exp_rd); end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_both_strobes();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
